pipe_stage_reg: RTL

- Generic, parametrised pipeline-stage register that replaces the fixed per-stage latch interfaces (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of WIDTH bits, normally a packed stage struct from pipe_types_pkg.
- Uses a valid/ready handshake, with an optional skid entry so the upstream ready does not depend combinationally on the downstream ready.
- Adds flush, stall, global enable, occupancy status and a saturating bubble counter for hazard-unit tuning.

---
 rtl/pipe_types_pkg.sv | 44 ++++
 rtl/pipe_skid_entry.sv | 25 ++
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_types_pkg.sv
// Shared pipeline types: stage payload structs, stage-register FSM state and counter type.
package pipe_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int STAGE_CNT_W = 16;
  typedef logic [STAGE_CNT_W-1:0] stage_cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// Single holding entry: payload register with load strobe plus a separately written valid bit.
module pipe_skid_entry #(
  parameter int WIDTH = 256
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             valid_we,
  input  logic             valid_d,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      if (valid_we) valid <= valid_d;
      if (load)     q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline-stage register with optional skid entry, flush/stall/enable,
// occupancy status and a saturating bubble counter.
module pipe_stage_reg
  import pipe_types_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] OCC_MAX = (SKID != 0) ? 2'd2 : 2'd1;

  stage_state_t     state_reg, state_next;
  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             main_load, main_from_skid, skid_load;
  logic             acc, pop;
  logic [CNT_W-1:0] bubble_reg;

  assign out_valid  = main_valid & en & ~stall;
  assign out_data   = main_q;
  assign acc        = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign occupancy  = occ_count(main_valid, skid_valid);
  assign bubble_cnt = bubble_reg;

  // nRST gating keeps in_ready low while reset is asserted, independent of the clock.
  generate
    if (SKID != 0) begin : g_ready_skid
      assign in_ready = nRST & en & ~skid_valid & ~flush;
    end else begin : g_ready_pass
      assign in_ready = nRST & en & ~flush & (~main_valid | (out_ready & ~stall));
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (en) begin
      if (flush) begin
        state_next = EMPTY;
      end else begin
        case (state_reg)
          EMPTY: if (acc) begin
            state_next = HALF;
            main_load  = 1'b1;
          end
          HALF: begin
            if (acc && pop) begin
              main_load = 1'b1;
            end else if (acc && SKID != 0) begin
              state_next = FULL;
              skid_load  = 1'b1;
            end else if (pop) begin
              state_next = EMPTY;
            end
          end
          FULL: if (pop) begin
            state_next     = HALF;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
          default: state_next = EMPTY;
        endcase
      end
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_skid_entry #(.WIDTH(WIDTH)) u_main (
    .CLK      (CLK),
    .nRST     (nRST),
    .valid_we (en),
    .valid_d  (state_next != EMPTY),
    .load     (main_load),
    .d        (main_d),
    .valid    (main_valid),
    .q        (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_entry #(.WIDTH(WIDTH)) u_skid (
        .CLK      (CLK),
        .nRST     (nRST),
        .valid_we (en),
        .valid_d  (state_next == FULL),
        .load     (skid_load),
        .d        (in_data),
        .valid    (skid_valid),
        .q        (skid_q)
      );
    end else begin : g_no_skid
      logic unused_skid_load;
      assign unused_skid_load = skid_load;
      assign skid_valid       = 1'b0;
      assign skid_q           = '0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= EMPTY;
      bubble_reg <= '0;
    end else if (en) begin
      state_reg <= state_next;
      if (!flush && !out_valid && bubble_reg != {CNT_W{1'b1}})
        bubble_reg <= bubble_reg + CNT_W'(1);
    end
  end

  always @(posedge CLK) begin
    if (nRST) begin
      assert (!skid_valid || main_valid);
      assert (occupancy <= OCC_MAX);
    end
  end

endmodule
